peripheral_bus_bridge: RTL and testbench
========================================

# peripheral_bus_bridge

Wishbone classic slave to internal peripheral-bus master bridge; sits directly upstream of the GPIO and other peripherals, driving the shared peripheral bus they decode with their 8-bit IDs. Converts each Wishbone cycle in its address window into one peripheral-bus access and returns the read data or write completion as `wb_ack_o`. Handles `peripheralBus_busy` wait states and drops aborted cycles cleanly.

## Interface
Parameters:
- `BASE_ADDR`, 8'h13: `wb_adr_i[31:24]` value claimed by the bridge.
- `TIMEOUT_CYCLES`, 255: maximum busy cycles before abort; used only with the timeout feature.

Ports:
- `clk`  in  1  sole clock; everything is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wb_cyc_i`  in  1  Wishbone cycle.
- `wb_stb_i`  in  1  Wishbone strobe.
- `wb_we_i`  in  1  write enable.
- `wb_sel_i`  in  4  byte select.
- `wb_adr_i`  in  32  byte address.
- `wb_data_i`  in  32  write data.
- `wb_ack_o`  out  1  one-cycle acknowledge.
- `wb_error_o`  out  1  one-cycle error (timeout).
- `wb_data_o`  out  32  read data, valid with `wb_ack_o`.
- `peripheralBus_we`  out  1  write strobe.
- `peripheralBus_oe`  out  1  read strobe.
- `peripheralBus_busy`  in  1  addressed peripheral stalls the access.
- `peripheralBus_address`  out  24  latched `wb_adr_i[23:0]`.
- `peripheralBus_byteSelect`  out  4  latched `wb_sel_i`.
- `peripheralBus_dataWrite`  out  32  latched `wb_data_i`.
- `peripheralBus_dataRead`  in  32  peripheral read data.
- `requestOutput`  in  1  a peripheral is driving `peripheralBus_dataRead`.

## Operation
- Reset values: all outputs 0; state IDLE; latches 0.
- States:
  - IDLE: on `wb_cyc_i && wb_stb_i && wb_adr_i[31:24]==BASE_ADDR`, latch address, sel, data and we, then go to ACCESS. Out-of-window requests are ignored (no ack, no error).
  - ACCESS: assert `peripheralBus_we` (write) or `peripheralBus_oe` (read), never both.
    - If `peripheralBus_busy`=0, capture read data and go to ACK.
    - Otherwise go to WAIT.
  - WAIT: hold strobes and latched outputs.
    - Leave for ACK on the first cycle with `peripheralBus_busy`=0, capturing data that cycle.
  - ACK: `wb_ack_o`=1 for exactly one cycle, strobes 0, then go to IDLE.
  - ERROR (timeout build only): `wb_error_o`=1 for one cycle, then go to IDLE.
- Read capture: `wb_data_o` = `requestOutput ? peripheralBus_dataRead : 32'h0`. It holds until the next capture. On writes `wb_data_o` keeps its previous value.
- Abort: if `wb_cyc_i`=0 in ACCESS or WAIT, go to IDLE next cycle with no ack or error. A write already strobed is not undone.
- ACK or ERROR state with `wb_cyc_i` low: still returns to IDLE; the ack or error pulse is emitted regardless.
- IDLE re-arms only in the cycle after ACK or ERROR, so back-to-back requests cost one idle cycle.
- Reset asserted mid-transfer: strobes, ack and error drop asynchronously; state goes to IDLE.

## Timing
- Request accepted at edge N. Strobe is high during cycle N+1.
- Zero wait states: `wb_ack_o` is high in cycle N+2.
- Each busy cycle sampled adds one cycle.
- Strobe width equals 1 + number of busy cycles.
- `peripheralBus_address`, `peripheralBus_byteSelect` and `peripheralBus_dataWrite` are stable from N+1 until the strobe drops.

## Configuration
- `PERIPHERAL_BUS_BRIDGE_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments every WAIT cycle.
  - When WAIT reaches `TIMEOUT_CYCLES` with busy still high, go to ERROR.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- Undefined:
  - WAIT lasts indefinitely; no counter logic exists.
  - `wb_error_o` is tied 0 and the ERROR state is not present.

## Structure
- Shared package holds:
  - state encodings (IDLE=0, ACCESS=1, WAIT=2, ACK=3, ERROR=4);
  - `PERIPHERAL_ADDRESS_WIDTH`=24;
  - `PERIPHERAL_ID_WIDTH`=8.
- One natural sub-module: `bus_timeout_counter` (clear, enable, expired). Instantiated only under the macro.
- FSM and latches stay in the top.

## Test plan
- Read, zero waits: Wishbone read at 0x1300_0010; peripheral returns 0xDEAD_BEEF with `requestOutput`=1.
  - `peripheralBus_oe` high for 1 cycle with address 0x00_0010.
  - `wb_ack_o` in cycle N+2 with `wb_data_o`=0xDEAD_BEEF.
- Write with waits: write 0x1234_5678, sel 4'b0011, busy high for 3 cycles.
  - `peripheralBus_we` high for 4 cycles.
  - `wb_ack_o` in cycle N+5.
  - `peripheralBus_dataWrite` stable at 0x1234_5678 throughout.
- Unclaimed read: read with `requestOutput`=0.
  - `wb_data_o`=0x0000_0000.
- Out of window: access at 0x1400_0000.
  - No strobe, no ack for 20 cycles.
- Abort: drop `wb_cyc_i` during the second busy cycle.
  - Strobe falls the next cycle, no ack.
  - A following read completes normally.
- Timeout (macro on, `TIMEOUT_CYCLES`=8): busy held high.
  - `wb_error_o` pulses once, no ack, FSM back in IDLE.
  - Asserting `rst` mid-WAIT clears all outputs immediately.

Source files
------------

// File: rtl/peripheral_bus_bridge_pkg.sv
// Shared definitions for the Wishbone-to-peripheral-bus bridge: FSM state
// encodings and peripheral bus field widths.
package peripheral_bus_bridge_pkg;

    localparam int PERIPHERAL_ADDRESS_WIDTH = 24;
    localparam int PERIPHERAL_ID_WIDTH      = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACK    = 3'd3,
        ST_ERROR  = 3'd4
    } bridge_state_t;

endpackage

// File: rtl/peripheral_bus_bridge_bus_timeout_counter.sv
// Wait-state counter for the bridge: cleared when an access starts, counts
// busy cycles, and flags when the final permitted busy cycle is reached.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [COUNT_WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Count holds the WAIT cycles already completed, so the current one is the last.
    assign expired = (count_reg == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/peripheral_bus_bridge.sv
// Wishbone classic slave to peripheral-bus master bridge. Optional busy
// timeout is enabled by defining PERIPHERAL_BUS_BRIDGE_TIMEOUT_EN.
module peripheral_bus_bridge
    import peripheral_bus_bridge_pkg::*;
#(
    parameter logic [PERIPHERAL_ID_WIDTH-1:0] BASE_ADDR      = 8'h13,
    parameter int                             TIMEOUT_CYCLES = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wb_cyc_i,
    input  logic                                wb_stb_i,
    input  logic                                wb_we_i,
    input  logic [3:0]                          wb_sel_i,
    input  logic [31:0]                         wb_adr_i,
    input  logic [31:0]                         wb_data_i,
    output logic                                wb_ack_o,
    output logic                                wb_error_o,
    output logic [31:0]                         wb_data_o,
    output logic                                peripheralBus_we,
    output logic                                peripheralBus_oe,
    input  logic                                peripheralBus_busy,
    output logic [PERIPHERAL_ADDRESS_WIDTH-1:0] peripheralBus_address,
    output logic [3:0]                          peripheralBus_byteSelect,
    output logic [31:0]                         peripheralBus_dataWrite,
    input  logic [31:0]                         peripheralBus_dataRead,
    input  logic                                requestOutput
);

    bridge_state_t state_reg, state_next;

    logic                                accept;
    logic                                capture;
    logic                                strobe_active;
    logic                                we_reg;
    logic [PERIPHERAL_ADDRESS_WIDTH-1:0] address_reg;
    logic [3:0]                          sel_reg;
    logic [31:0]                         data_write_reg;
    logic [31:0]                         data_read_reg;

`ifdef PERIPHERAL_BUS_BRIDGE_TIMEOUT_EN
    logic timeout_expired;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (state_reg == ST_WAIT),
        .expired(timeout_expired)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i &&
                    wb_adr_i[31:PERIPHERAL_ADDRESS_WIDTH] == BASE_ADDR) begin
                    accept     = 1'b1;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS, ST_WAIT: begin
                // A dropped cycle abandons the access; busy is irrelevant then.
                if (!wb_cyc_i) begin
                    state_next = ST_IDLE;
                end else if (!peripheralBus_busy) begin
                    capture    = !we_reg;
                    state_next = ST_ACK;
`ifdef PERIPHERAL_BUS_BRIDGE_TIMEOUT_EN
                end else if (state_reg == ST_WAIT && timeout_expired) begin
                    state_next = ST_ERROR;
`endif
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
`ifdef PERIPHERAL_BUS_BRIDGE_TIMEOUT_EN
            ST_ERROR: begin
                state_next = ST_IDLE;
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_reg         <= 1'b0;
            address_reg    <= '0;
            sel_reg        <= '0;
            data_write_reg <= '0;
        end else if (accept) begin
            we_reg         <= wb_we_i;
            address_reg    <= wb_adr_i[PERIPHERAL_ADDRESS_WIDTH-1:0];
            sel_reg        <= wb_sel_i;
            data_write_reg <= wb_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_read_reg <= '0;
        end else if (capture) begin
            data_read_reg <= requestOutput ? peripheralBus_dataRead : 32'h0;
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    assign strobe_active            = (state_reg == ST_ACCESS) || (state_reg == ST_WAIT);
    assign peripheralBus_we         = strobe_active && we_reg;
    assign peripheralBus_oe         = strobe_active && !we_reg;
    assign peripheralBus_address    = address_reg;
    assign peripheralBus_byteSelect = sel_reg;
    assign peripheralBus_dataWrite  = data_write_reg;
    assign wb_ack_o                 = (state_reg == ST_ACK);
    assign wb_data_o                = data_read_reg;

`ifdef PERIPHERAL_BUS_BRIDGE_TIMEOUT_EN
    assign wb_error_o = (state_reg == ST_ERROR);
`else
    assign wb_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_peripheral_bus_bridge.sv
// Randomised bench for peripheral_bus_bridge against a transaction-level model.
module tb_peripheral_bus_bridge;

    localparam logic [7:0] BASE = 8'h13;
    localparam int         TO   = 8;
`ifdef PERIPHERAL_BUS_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_adr_i = '0, wb_data_i = '0;
    logic        wb_ack_o, wb_error_o;
    logic [31:0] wb_data_o;
    logic        peripheralBus_we, peripheralBus_oe;
    logic        peripheralBus_busy = 1'b0;
    logic [23:0] peripheralBus_address;
    logic [3:0]  peripheralBus_byteSelect;
    logic [31:0] peripheralBus_dataWrite;
    logic [31:0] peripheralBus_dataRead = '0;
    logic        requestOutput = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] model_rdata = 32'h0;

    always #5 clk = ~clk;

    peripheral_bus_bridge #(
        .BASE_ADDR     (BASE),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .wb_cyc_i                (wb_cyc_i),
        .wb_stb_i                (wb_stb_i),
        .wb_we_i                 (wb_we_i),
        .wb_sel_i                (wb_sel_i),
        .wb_adr_i                (wb_adr_i),
        .wb_data_i               (wb_data_i),
        .wb_ack_o                (wb_ack_o),
        .wb_error_o              (wb_error_o),
        .wb_data_o               (wb_data_o),
        .peripheralBus_we        (peripheralBus_we),
        .peripheralBus_oe        (peripheralBus_oe),
        .peripheralBus_busy      (peripheralBus_busy),
        .peripheralBus_address   (peripheralBus_address),
        .peripheralBus_byteSelect(peripheralBus_byteSelect),
        .peripheralBus_dataWrite (peripheralBus_dataWrite),
        .peripheralBus_dataRead  (peripheralBus_dataRead),
        .requestOutput           (requestOutput)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One Wishbone transaction; the peripheral holds busy for busy_n sampled
    // cycles, and abort_at (>0) drops wb_cyc_i during that strobe cycle.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] wd, input int busy_n, input logic ro,
                           input logic [31:0] rd, input int abort_at);
        bit hit;
        int exp_width, exp_ack_c, exp_err_c, limit;
        int width_obs, we_obs, oe_obs, ack_obs, err_obs, ack_c, err_c;
        hit = (adr[31:24] == BASE);
        exp_ack_c = 0;
        exp_err_c = 0;
        if (!hit) begin
            exp_width = 0;
        end else if (abort_at > 0) begin
            exp_width = abort_at;
        end else if (TO_EN && busy_n >= TO) begin
            exp_width = 1 + TO;
            exp_err_c = 2 + TO;
        end else begin
            exp_width = 1 + busy_n;
            exp_ack_c = 2 + busy_n;
        end
        if (exp_ack_c != 0 && !we) model_rdata = ro ? rd : 32'h0;
        limit = hit ? ((exp_ack_c > exp_err_c ? exp_ack_c : exp_err_c) + exp_width + 3) : 20;
        width_obs = 0; we_obs = 0; oe_obs = 0; ack_obs = 0; err_obs = 0; ack_c = 0; err_c = 0;

        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_sel_i = sel; wb_data_i = wd;
        peripheralBus_busy = 1'b0; peripheralBus_dataRead = rd; requestOutput = ro;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (peripheralBus_we || peripheralBus_oe) begin
                width_obs++;
                check_value("bus_address", {8'h0, peripheralBus_address}, {8'h0, adr[23:0]});
                check_value("bus_byte_select", {28'h0, peripheralBus_byteSelect}, {28'h0, sel});
                check_value("bus_data_write", peripheralBus_dataWrite, wd);
            end
            we_obs += int'(peripheralBus_we);
            oe_obs += int'(peripheralBus_oe);
            if (wb_ack_o) begin
                ack_obs++;
                if (ack_c == 0) ack_c = c;
                check_value("ack_read_data", wb_data_o, model_rdata);
            end
            if (wb_error_o) begin
                err_obs++;
                if (err_c == 0) err_c = c;
            end
            if (wb_ack_o || wb_error_o) begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0; peripheralBus_busy = 1'b0;
                break;
            end
            peripheralBus_busy = (c <= busy_n);
            if (c == abort_at) begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; peripheralBus_busy = 1'b0;

        check_value("strobe_width", width_obs, exp_width);
        check_value("we_cycles", we_obs, we ? exp_width : 0);
        check_value("oe_cycles", oe_obs, we ? 0 : exp_width);
        check_value("ack_cycle", ack_c, exp_ack_c);
        check_value("ack_count", ack_obs, exp_ack_c != 0 ? 1 : 0);
        check_value("err_cycle", err_c, exp_err_c);
        check_value("err_count", err_obs, exp_err_c != 0 ? 1 : 0);
        check_value("wb_data_o", wb_data_o, model_rdata);
        $display("txn we=%0b adr=%08h busy=%0d ro=%0b abort=%0d width=%0d ack_c=%0d err_c=%0d rdata=%08h",
                 we, adr, busy_n, ro, abort_at, width_obs, ack_c, err_c, wb_data_o);
    endtask

    initial begin
        logic        r_we, r_ro;
        logic [31:0] r_adr;
        int          r_busy, r_abort;

        repeat (3) @(negedge clk);
        check_value("reset_ack", {31'h0, wb_ack_o}, 32'h0);
        check_value("reset_oe", {31'h0, peripheralBus_oe}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_value("reset_we", {31'h0, peripheralBus_we}, 32'h0);
        check_value("reset_err", {31'h0, wb_error_o}, 32'h0);
        check_value("reset_rdata", wb_data_o, 32'h0);
        check_value("reset_address", {8'h0, peripheralBus_address}, 32'h0);
        check_value("reset_data_write", peripheralBus_dataWrite, 32'h0);

        run_txn(1'b0, 32'h1300_0010, 4'hF, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, 0);
        run_txn(1'b1, 32'h1300_0044, 4'b0011, 32'h1234_5678, 3, 1'b0, 32'h0, 0);
        run_txn(1'b0, 32'h1300_0020, 4'hF, 32'h0, 1, 1'b0, 32'hCAFE_F00D, 0);
        run_txn(1'b0, 32'h1400_0000, 4'hF, 32'h0, 0, 1'b1, 32'h5555_AAAA, 0);
        run_txn(1'b0, 32'h1300_0030, 4'hF, 32'h0, 3, 1'b1, 32'hBAD0_0BAD, 2);
        run_txn(1'b0, 32'h1300_0034, 4'hF, 32'h0, 0, 1'b1, 32'h0BAD_F00D, 0);
        if (TO_EN) begin
            run_txn(1'b0, 32'h1300_0040, 4'hF, 32'h0, 20, 1'b1, 32'h1111_2222, 0);
            run_txn(1'b0, 32'h1300_0044, 4'hF, 32'h0, 0, 1'b1, 32'h3333_4444, 0);
        end

        for (int i = 0; i < 60; i++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_ro    = ($urandom_range(0, 3) != 0);
            r_busy  = int'($urandom_range(0, 5));
            r_adr   = $urandom;
            r_adr[31:24] = ($urandom_range(0, 9) < 8) ? BASE : 8'(BASE + 8'($urandom_range(1, 200)));
            r_abort = (r_busy > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, r_busy)) : 0;
            run_txn(r_we, r_adr, 4'($urandom), $urandom, r_busy, r_ro, $urandom, r_abort);
        end

        // Reset asserted mid-WAIT must drop the strobe without waiting for an edge.
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 32'h1300_0100; peripheralBus_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_value("wait_oe_before_reset", {31'h0, peripheralBus_oe}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check_value("async_reset_oe", {31'h0, peripheralBus_oe}, 32'h0);
        check_value("async_reset_ack", {31'h0, wb_ack_o}, 32'h0);
        check_value("async_reset_err", {31'h0, wb_error_o}, 32'h0);
        check_value("async_reset_rdata", wb_data_o, 32'h0);
        model_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; peripheralBus_busy = 1'b0;
        run_txn(1'b0, 32'h1300_0200, 4'hF, 32'h0, 2, 1'b1, 32'h7777_8888, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
